// File: rtl/flag_unit.sv
// flag_unit: producer of the {Z,V,N} condition flags.
//
// Derives raw flags from the EX-stage ALU result, merges them into the
// architectural flag register under a per-opcode update mask, and presents
// flags to the ID-stage branch resolver. With FWD=1 the EX-stage merged
// value is forwarded combinationally. With FWD=0 a small FSM stalls a
// dependent branch for one cycle until the flags have committed.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   ex_valid   - EX stage holds a real instruction
//   ex_opcode  - EX-stage opcode
//   ex_result  - ALU result of the EX instruction
//   ex_ovfl    - ALU signed overflow (ADD/SUB)
//   stall      - pipeline stall, EX instruction re-presented next cycle
//   flush      - squash the EX instruction
//   id_opcode  - ID-stage opcode (hazard detection)
//   flags_out  - {Z,V,N} seen by the ID-stage branch logic
//   flag_reg   - architectural flag register {Z,V,N}
//   flag_stall - ID branch must wait (FWD=0 only)
module flag_unit #(
    parameter bit FWD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovfl,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  id_opcode,
    output logic [2:0]  flags_out,
    output logic [2:0]  flag_reg,
    output logic        flag_stall
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] mask;
    logic [2:0] raw;
    logic [2:0] merged;
    logic       writer;
    logic       wr;
    logic       id_branch;
    logic       hazard;

    // Update mask, bit order {Z,V,N}.
    always_comb begin
        mask = '0;
        case (ex_opcode)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
            default:                        mask = '0;
        endcase
    end

    assign raw    = {(ex_result == 16'h0000), ex_ovfl, ex_result[15]};
    assign merged = (flag_reg & ~mask) | (raw & mask);

    // A live flag writer in EX, regardless of stall: its flags are final.
    assign writer = ex_valid & ~flush & (mask != '0);
    assign wr     = writer & ~stall;

    assign id_branch = (id_opcode == OP_B) || (id_opcode == OP_BR);
    assign hazard    = ~FWD & writer & id_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg <= '0;
            state    <= ST_IDLE;
        end else begin
            if (wr) begin
                flag_reg <= merged;
            end
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        flag_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hazard) begin
                    flag_stall = 1'b1;
                    // The writer commits on this same edge, so WAIT sees it.
                    if (!stall) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_nxt  = ST_IDLE;
            flag_stall = 1'b0;
        end
        // Reset dominates the combinational outputs as well as the state.
        if (rst) begin
            flag_stall = 1'b0;
        end
    end

    always_comb begin
        flags_out = flag_reg;
        if (FWD && writer && !rst) begin
            flags_out = merged;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic        stall;
    logic        flush;
    logic [3:0]  id_opcode;

    logic [2:0]  fo_f, fr_f;
    logic        fs_f;
    logic [2:0]  fo_n, fr_n;
    logic        fs_n;

    int unsigned tests;
    int unsigned fails;

    flag_unit #(.FWD(1'b1)) u_fwd (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_result  (ex_result),
        .ex_ovfl    (ex_ovfl),
        .stall      (stall),
        .flush      (flush),
        .id_opcode  (id_opcode),
        .flags_out  (fo_f),
        .flag_reg   (fr_f),
        .flag_stall (fs_f)
    );

    flag_unit #(.FWD(1'b0)) u_nofwd (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_result  (ex_result),
        .ex_ovfl    (ex_ovfl),
        .stall      (stall),
        .flush      (flush),
        .id_opcode  (id_opcode),
        .flags_out  (fo_n),
        .flag_reg   (fr_n),
        .flag_stall (fs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic st, input logic fl, input logic [3:0] idop);
        ex_valid  = v;
        ex_opcode = op;
        ex_result = res;
        ex_ovfl   = ov;
        stall     = st;
        flush     = fl;
        id_opcode = idop;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset while an ADD with zero result is in EX.
        rst = 1'b1;
        drive(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        check("rst_fo_fwd", fo_f, 3'b000);
        check("rst_fs_nofwd", {2'b00, fs_n}, 3'b000);
        tick();
        check("rst_fr_fwd", fr_f, 3'b000);
        check("rst_fr_nofwd", fr_n, 3'b000);
        rst = 1'b0;
        #1;
        check("post_rst_fwd_fo", fo_f, 3'b100);
        check("post_rst_nofwd_fo", fo_n, 3'b000);
        tick();
        check("add0_fr_fwd", fr_f, 3'b100);
        check("add0_fr_nofwd", fr_n, 3'b100);

        // SUB 0x8000 with overflow: Z=0 V=1 N=1.
        drive(1'b1, 4'b0001, 16'h8000, 1'b1, 1'b0, 1'b0, 4'b0000);
        #1;
        check("sub_fwd_fo_same_cycle", fo_f, 3'b011);
        check("sub_nofwd_fo_old", fo_n, 3'b100);
        check("sub_nofwd_no_stall", {2'b00, fs_n}, 3'b000);
        tick();
        check("sub_fr", fr_f, 3'b011);
        check("sub_fr_nofwd", fr_n, 3'b011);

        // XOR zero result updates only Z.
        drive(1'b1, 4'b0010, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        check("xor_keep_vn", fr_f, 3'b111);
        // LW and HLT never write.
        drive(1'b1, 4'b1000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        #1;
        check("lw_fo", fo_f, 3'b111);
        tick();
        check("lw_no_write", fr_f, 3'b111);
        drive(1'b1, 4'b1111, 16'h8000, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        check("hlt_no_write", fr_f, 3'b111);

        // ADD 5 stalled for two cycles: forwarded immediately, committed on third edge.
        drive(1'b1, 4'b0000, 16'h0005, 1'b0, 1'b1, 1'b0, 4'b0000);
        #1;
        check("stall_fwd_fo", fo_f, 3'b000);
        tick();
        check("stall_edge1", fr_f, 3'b111);
        tick();
        check("stall_edge2", fr_f, 3'b111);
        stall = 1'b0;
        tick();
        check("stall_edge3", fr_f, 3'b000);
        check("stall_edge3_nofwd", fr_n, 3'b000);

        // Flush, stall+flush, and bubble all suppress the write.
        drive(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        #1;
        check("flush_fo", fo_f, 3'b000);
        tick();
        check("flush_no_write", fr_f, 3'b000);
        drive(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1, 1'b1, 4'b0000);
        tick();
        check("stall_flush_no_write", fr_f, 3'b000);
        drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        check("bubble_no_write", fr_f, 3'b000);

        // FWD=0 hazard: branch in ID, SUB zero in EX.
        drive(1'b1, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1100);
        #1;
        check("haz_stall_nofwd", {2'b00, fs_n}, 3'b001);
        check("haz_no_stall_fwd", {2'b00, fs_f}, 3'b000);
        tick();
        drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1100);
        #1;
        check("wait_stall_low", {2'b00, fs_n}, 3'b000);
        check("wait_fo", fo_n, 3'b100);
        tick();

        // Same writer with a non-branch in ID: no stall.
        drive(1'b1, 4'b0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        #1;
        check("nobranch_no_stall", {2'b00, fs_n}, 3'b000);
        tick();
        check("nobranch_fr", fr_n, 3'b110);
        check("nobranch_no_stall_after", {2'b00, fs_n}, 3'b000);

        // Hazard with stall held 3 cycles, then one more stalled cycle.
        drive(1'b1, 4'b0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("haz_held_stall", {2'b00, fs_n}, 3'b001);
            tick();
        end
        check("haz_held_no_commit", fr_n, 3'b110);
        stall = 1'b0;
        #1;
        check("haz_release_stall", {2'b00, fs_n}, 3'b001);
        tick();
        check("haz_release_fr", fr_n, 3'b001);
        check("haz_release_wait", {2'b00, fs_n}, 3'b000);

        // Reset in WAIT returns to IDLE: a new hazard stalls right away.
        rst = 1'b1;
        drive(1'b1, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1100);
        #1;
        check("rst_in_wait_stall", {2'b00, fs_n}, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        check("rst_wait_fr", fr_n, 3'b000);
        check("rst_wait_idle", {2'b00, fs_n}, 3'b001);

        // Flush kills the hazard, no commit, FSM stays IDLE.
        flush = 1'b1;
        #1;
        check("flush_haz_stall", {2'b00, fs_n}, 3'b000);
        tick();
        check("flush_haz_fr", fr_n, 3'b000);
        flush = 1'b0;
        #1;
        check("flush_haz_idle", {2'b00, fs_n}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
